// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Execution sequencer for the single-cycle RV32 core. It decides each cycle
//   whether the current instruction commits. commit_o gates the PC update and
//   is ANDed with RegWrite, so an uncommitted instruction changes no
//   architectural state. It provides run/halt/single-step, one PC breakpoint,
//   a retired-instruction counter and an optional retire limit.
//
// Parameters
//   CNT_W      width of the retired-instruction counter
//   MAX_RETIRE retire limit, 0 = no limit
//   AUTO_RUN   1 = leave reset in RUN instead of HALTED
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   run_i      pulse: enter continuous execution
//   halt_i     pulse/level: stop continuous execution
//   step_i     pulse: execute exactly one instruction
//   clr_cnt_i  synchronous clear of retire counter and limit flag
//   bp_en_i    breakpoint enable
//   bp_addr_i  breakpoint PC (word aligned)
//   pc_i       current instruction address
//   commit_o   current instruction commits (combinational)
//   state_o    0=HALTED 1=RUN 2=STEP 3=BRK
//   bp_hit_o   one-cycle pulse on the first cycle in BRK
//   limit_o    sticky: stopped because MAX_RETIRE was reached
//   retired_o  number of committed instructions (wraps)
module cpu_run_controller #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_RETIRE = 0,
  parameter bit          AUTO_RUN   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             step_i,
  input  logic             clr_cnt_i,
  input  logic             bp_en_i,
  input  logic [31:0]      bp_addr_i,
  input  logic [31:0]      pc_i,
  output logic             commit_o,
  output logic [1:0]       state_o,
  output logic             bp_hit_o,
  output logic             limit_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    BRK    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_RETIRE);
  localparam bit               LIMIT_EN = (MAX_RETIRE != 0);

  state_t           state;
  logic             skip;
  logic             bp_hit;
  logic             limit;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] retired_next;
  logic             bp_match;
  logic             commit;
  logic             at_limit;

  // skip suppresses the breakpoint for the one instruction being resumed from BRK
  always_comb begin
    bp_match     = bp_en_i && (pc_i == bp_addr_i) && !skip;
    retired_next = retired + CNT_W'(1);
    at_limit     = LIMIT_EN && (retired_next == LIMIT);
    commit       = 1'b0;
    case (state)
      STEP:    commit = 1'b1;
      RUN:     commit = !bp_match;
      default: commit = 1'b0;
    endcase
    // Reset must force commit low at once, even when AUTO_RUN resets into RUN
    commit = commit && !rst_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= AUTO_RUN ? RUN : HALTED;
      skip    <= 1'b0;
      bp_hit  <= 1'b0;
      limit   <= 1'b0;
      retired <= '0;
    end else begin
      bp_hit <= 1'b0;

      if (clr_cnt_i)   retired <= '0;
      else if (commit) retired <= retired_next;

      if (clr_cnt_i) limit <= 1'b0;

      case (state)
        HALTED, BRK: begin
          if (run_i) begin
            state <= RUN;
            skip  <= (state == BRK);
          end else if (step_i) begin
            state <= STEP;
            skip  <= (state == BRK);
          end
        end
        STEP: begin
          state <= HALTED;
          skip  <= 1'b0;
        end
        RUN: begin
          if (bp_match) begin
            state  <= BRK;
            bp_hit <= 1'b1;
          end else begin
            skip <= 1'b0;
            if (halt_i) begin
              state <= HALTED;
            end else if (at_limit) begin
              state <= HALTED;
              if (!clr_cnt_i) limit <= 1'b1;
            end
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  assign commit_o  = commit;
  assign state_o   = state;
  assign bp_hit_o  = bp_hit;
  assign limit_o   = limit;
  assign retired_o = retired;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller: table of per-cycle vectors checked through
// an expectation queue, plus hand sequences for retire limit, async reset,
// AUTO_RUN and counter wrap.
module tb_cpu_run_controller;

  typedef struct {
    logic        run, halt, step, clr, bp_en;
    logic [31:0] pc;
    logic        commit;
    logic [1:0]  state;
    logic        bp_hit;
    logic        limit;
    logic [31:0] retired;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, halt = 1'b0, step = 1'b0, clr_cnt = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h10;
  logic [31:0] pc = '0;

  logic        commit0, bp_hit0, limit0;
  logic [1:0]  state0;
  logic [31:0] retired0;
  logic        lim_commit, lim_bp_hit, lim_limit;
  logic [1:0]  lim_state;
  logic [31:0] lim_retired;
  logic        wrap_commit, wrap_bp_hit, wrap_limit;
  logic [1:0]  wrap_state;
  logic [3:0]  wrap_retired;
  logic        auto_commit, auto_bp_hit, auto_limit;
  logic [1:0]  auto_state;
  logic [31:0] auto_retired;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  cpu_run_controller dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .halt_i(halt), .step_i(step),
    .clr_cnt_i(clr_cnt), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .commit_o(commit0), .state_o(state0), .bp_hit_o(bp_hit0),
    .limit_o(limit0), .retired_o(retired0));

  cpu_run_controller #(.MAX_RETIRE(5)) dut_lim (
    .clk_i(clk), .rst_i(rst), .run_i(run), .halt_i(halt), .step_i(step),
    .clr_cnt_i(clr_cnt), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .commit_o(lim_commit), .state_o(lim_state), .bp_hit_o(lim_bp_hit),
    .limit_o(lim_limit), .retired_o(lim_retired));

  cpu_run_controller #(.CNT_W(4)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .run_i(run), .halt_i(halt), .step_i(step),
    .clr_cnt_i(clr_cnt), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .commit_o(wrap_commit), .state_o(wrap_state), .bp_hit_o(wrap_bp_hit),
    .limit_o(wrap_limit), .retired_o(wrap_retired));

  cpu_run_controller #(.AUTO_RUN(1'b1)) dut_auto (
    .clk_i(clk), .rst_i(rst), .run_i(run), .halt_i(halt), .step_i(step),
    .clr_cnt_i(clr_cnt), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .commit_o(auto_commit), .state_o(auto_state), .bp_hit_o(auto_bp_hit),
    .limit_o(auto_limit), .retired_o(auto_retired));

  function automatic vec_t mk(input logic r, h, s, c, be, input logic [31:0] p,
                              input logic cm, input logic [1:0] st,
                              input logic bh, input logic [31:0] ret);
    vec_t v;
    v.run = r; v.halt = h; v.step = s; v.clr = c; v.bp_en = be; v.pc = p;
    v.commit = cm; v.state = st; v.bp_hit = bh; v.limit = 1'b0; v.retired = ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, h, s, c);
    @(posedge clk);
    #1;
    run = r; halt = h; step = s; clr_cnt = c; bp_en = 1'b0; pc = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    run = 0; halt = 0; step = 0; clr_cnt = 0; bp_en = 0; pc = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply_row(input int idx, input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    run = v.run; halt = v.halt; step = v.step; clr_cnt = v.clr;
    bp_en = v.bp_en; pc = v.pc;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("row%0d commit", idx), 32'(commit0), 32'(e.commit));
    check($sformatf("row%0d state", idx), 32'(state0), 32'(e.state));
    check($sformatf("row%0d bp_hit", idx), 32'(bp_hit0), 32'(e.bp_hit));
    check($sformatf("row%0d limit", idx), 32'(limit0), 32'(e.limit));
    check($sformatf("row%0d retired", idx), retired0, e.retired);
  endtask

  initial begin
    int ncommit;

    // ---- vector table: fields run,halt,step,clr,bp_en,pc | commit,state,bp_hit,retired
    tbl.push_back(mk(0,0,0,0,0,32'h0, 0,0,0,0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0,0,1,0,0,32'h0, 0,0,0,k));
      tbl.push_back(mk(0,0,0,0,0,32'h0, 1,2,0,k));
      tbl.push_back(mk(0,0,0,0,0,32'h0, 0,0,0,k+1));
      tbl.push_back(mk(0,1,0,0,0,32'h0, 0,0,0,k+1));   // halt ignored in HALTED
    end
    tbl.push_back(mk(0,0,0,1,0,32'h0, 0,0,0,3));
    // run, ten commits, halt on the tenth; step mid-run is ignored
    tbl.push_back(mk(1,0,0,0,0,32'h0, 0,0,0,0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, i == 9, i == 4, 0, 0, 32'(4*i), 1,1,0,32'(i)));
    tbl.push_back(mk(0,0,0,0,0,32'h28, 0,0,0,10));
    tbl.push_back(mk(0,0,0,1,0,32'h28, 0,0,0,10));
    // breakpoint at 0x10
    tbl.push_back(mk(1,0,0,0,1,32'h0, 0,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,1,32'(4*i), 1,1,0,32'(i)));
    tbl.push_back(mk(0,0,0,0,1,32'h10, 0,1,0,4));
    tbl.push_back(mk(0,0,0,0,1,32'h10, 0,3,1,4));
    tbl.push_back(mk(0,1,0,0,0,32'h10, 0,3,0,4));      // halt and bp_en change ignored in BRK
    tbl.push_back(mk(1,0,0,0,1,32'h10, 0,3,0,4));
    tbl.push_back(mk(0,0,0,0,1,32'h10, 1,1,0,4));      // resumed instruction commits
    tbl.push_back(mk(0,0,0,0,1,32'h14, 1,1,0,5));
    tbl.push_back(mk(0,0,0,0,1,32'h10, 0,1,0,6));      // loop back breaks again
    tbl.push_back(mk(0,0,0,0,1,32'h10, 0,3,1,6));
    tbl.push_back(mk(0,0,1,0,1,32'h10, 0,3,0,6));
    tbl.push_back(mk(0,0,0,0,1,32'h10, 1,2,0,6));
    tbl.push_back(mk(0,0,0,0,1,32'h14, 0,0,0,7));
    tbl.push_back(mk(0,0,1,0,1,32'h10, 0,0,0,7));
    tbl.push_back(mk(0,0,0,0,1,32'h10, 1,2,0,7));      // step ignores bp_match
    tbl.push_back(mk(0,0,0,0,1,32'h14, 0,0,0,8));
    tbl.push_back(mk(1,0,1,0,0,32'h100, 0,0,0,8));     // run wins over step
    tbl.push_back(mk(0,0,0,0,0,32'h100, 1,1,0,8));
    tbl.push_back(mk(0,1,0,0,0,32'h104, 1,1,0,9));
    tbl.push_back(mk(0,0,0,0,0,32'h108, 0,0,0,10));

    #12 rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) apply_row(i, tbl[i]);

    // ---- retire limit (MAX_RETIRE=5)
    do_reset();
    drive(1,0,0,0);
    ncommit = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0,0,0,0);
      @(negedge clk);
      if (lim_commit) ncommit++;
    end
    check("lim commits", 32'(ncommit), 32'd5);
    check("lim limit", 32'(lim_limit), 32'd1);
    check("lim retired", lim_retired, 32'd5);
    check("lim state", 32'(lim_state), 32'd0);
    check("nolimit still running", 32'(state0), 32'd1);
    drive(0,1,0,1);
    drive(0,0,0,0);
    @(negedge clk);
    check("lim clr limit", 32'(lim_limit), 32'd0);
    check("lim clr retired", lim_retired, 32'd0);
    drive(1,0,0,0);
    ncommit = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0,0,0,0);
      @(negedge clk);
      if (lim_commit) ncommit++;
    end
    check("lim rerun commits", 32'(ncommit), 32'd5);
    check("lim rerun retired", lim_retired, 32'd5);
    check("lim rerun limit", 32'(lim_limit), 32'd1);

    // ---- async reset mid-RUN, AUTO_RUN
    do_reset();
    drive(1,0,0,0);
    for (int i = 0; i < 3; i++) drive(0,0,0,0);
    @(negedge clk);
    check("pre-reset commit", 32'(commit0), 32'd1);
    check("pre-reset retired", retired0, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async commit", 32'(commit0), 32'd0);
    check("async retired", retired0, 32'd0);
    check("async state", 32'(state0), 32'd0);
    check("auto in-reset commit", 32'(auto_commit), 32'd0);
    check("auto in-reset state", 32'(auto_state), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("auto commit", 32'(auto_commit), 32'd1);
    check("auto state", 32'(auto_state), 32'd1);
    check("manual state", 32'(state0), 32'd0);

    // ---- counter wrap (CNT_W=4), 17 steps
    do_reset();
    ncommit = 0;
    for (int i = 0; i < 17; i++) begin
      drive(0,0,1,0);
      drive(0,0,0,0);
      @(negedge clk);
      if (wrap_commit) ncommit++;
    end
    drive(0,0,0,0);
    @(negedge clk);
    check("wrap commits", 32'(ncommit), 32'd17);
    check("wrap retired", 32'(wrap_retired), 32'd1);
    check("nowrap retired", retired0, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
